ofmap_write_ctrl: RTL and testbench

OFMAP_WRITE_CTRL -- requirements
Module: ofmap_write_ctrl

---
 rtl/ofmap_write_ctrl.sv | 133 +++++++++++++
 tb/tb_ofmap_write_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_write_ctrl.sv
// Output-feature-map write controller: four-state handshake FSM in front of
// a circular psum buffer that drains to a valid/ready downstream port.
module ofmap_write_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write_req,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  last_item,
    output logic [1:0]            stall,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  error
);

    localparam int DEPTH_N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [DATA_WIDTH-1:0] mem [DEPTH_N];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_last;
    logic                  push;
    logic                  pop;

    assign full      = (count == DEPTH);
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = mem[rptr];
    assign push      = (state == WRITE);
    assign pop       = out_valid && out_ready;

    // Acknowledge is a pure decode of the ACK state so reset/clear kill it at once.
    assign stall = (state == ACK) ? {1'b1, hold_last} : 2'b00;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = write_req ? CHECK : IDLE;
            CHECK:   next_state = full ? CHECK : WRITE;
            WRITE:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (clear) begin
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (state == IDLE && write_req) begin
            hold_data <= wdata;
            hold_last <= last_item;
        end
    end

    // A request outside IDLE is a protocol violation; it never touches the held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error <= 1'b0;
        end else if (clear) begin
            error <= 1'b0;
        end else if (write_req && state != IDLE) begin
            error <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wptr] <= hold_data;
        end
    end

endmodule

// File: tb/tb_ofmap_write_ctrl.sv
// Directed testbench for ofmap_write_ctrl with hand-computed expectations.
module tb_ofmap_write_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        write_req;
    logic [15:0] wdata;
    logic        last_item;
    logic [1:0]  stall;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    ofmap_write_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .write_req (write_req),
        .wdata     (wdata),
        .last_item (last_item),
        .stall     (stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // Issue one write and wait (bounded) for its ack; returns code and latency.
    task automatic do_write(input logic [15:0] d, input logic l,
                            output logic [1:0] st, output int lat);
        write_req = 1'b1;
        wdata     = d;
        last_item = l;
        step();
        write_req = 1'b0;
        lat = 1;
        for (int k = 0; k < 40; k++) begin
            if (stall != 2'b00) break;
            step();
            lat++;
        end
        st = stall;
        step();
    endtask

    task automatic test_reset();
        logic [1:0] st;
        int lat;
        do_reset();
        do_write(16'h0101, 1'b0, st, lat);
        do_write(16'h0202, 1'b0, st, lat);
        write_req = 1'b1;
        wdata = 16'h0303;
        step();
        write_req = 1'b1;
        step();
        write_req = 1'b0;
        reset = 1'b1;
        #2;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
            out_valid !== 1'b0 || stall !== 2'b00 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%0d emp=%b full=%b ov=%b st=%b err=%b required 0 1 0 0 00 0",
                     count, empty, full, out_valid, stall, error);
        end
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (count !== 5'd0 || stall !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: cnt=%0d st=%b required 0 00", count, stall);
        end
    endtask

    task automatic test_basic();
        logic [1:0] st;
        do_reset();
        out_ready = 1'b0;
        write_req = 1'b1;
        wdata     = 16'h1234;
        last_item = 1'b0;
        step();
        write_req = 1'b0;
        step();
        n_checks++;
        if (stall !== 2'b00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: st=%b ov=%b required 00 0", stall, out_valid);
        end
        step();
        n_checks++;
        if (stall !== 2'b10 || count !== 5'd1 || out_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_ack: st=%b cnt=%0d data=%h required 10 1 1234",
                     stall, count, out_data);
        end
        st = stall;
        step();
        n_checks++;
        if (stall !== 2'b00 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL basic_one_cycle: st=%b cnt=%0d required 00 1", stall, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pop: cnt=%0d emp=%b required 0 1", count, empty);
        end
    endtask

    task automatic test_fill();
        logic [1:0] st;
        logic [1:0] exp_st;
        int lat;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            do_write(16'hA000 + 16'(i), (i == 15), st, lat);
            exp_st = (i == 15) ? 2'b11 : 2'b10;
            n_checks++;
            if (st !== exp_st || lat != 3 || count !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_%0d: st=%b lat=%0d cnt=%0d required %b 3 %0d",
                         i, st, lat, count, exp_st, i + 1);
            end
        end
        n_checks++;
        if (full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full: full=%b required 1", full);
        end
        write_req = 1'b1;
        wdata     = 16'hBEEF;
        last_item = 1'b0;
        step();
        write_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (stall !== 2'b00 || full !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_blocked_%0d: st=%b full=%b required 00 1", k, stall, full);
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA000) begin
            n_fail++;
            $display("FAIL fill_head: ov=%b data=%h required 1 a000", out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (full !== 1'b0 || count !== 5'd15) begin
            n_fail++;
            $display("FAIL fill_popped: full=%b cnt=%0d required 0 15", full, count);
        end
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            if (stall != 2'b00) break;
            step();
            lat++;
        end
        n_checks++;
        if (lat != 2 || stall !== 2'b10 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_retry_ack: lat=%0d st=%b cnt=%0d required 2 10 16",
                     lat, stall, count);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [15:0] exp_q[$];
        int rx = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            write_req = 1'b1;
            wdata     = 16'h5000 + 16'(i * 3);
            last_item = (i == 19);
            exp_q.push_back(16'h5000 + 16'(i * 3));
            for (int c = 0; c < 4; c++) begin
                step();
                write_req = 1'b0;
                n_checks++;
                if (count > 5'd16) begin
                    n_fail++;
                    $display("FAIL wrap_count: cnt=%0d required <=16", count);
                end
                if (out_valid === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL wrap_extra: data=%h required no word", out_data);
                    end else begin
                        if (out_data !== exp_q[0]) begin
                            n_fail++;
                            $display("FAIL wrap_order_%0d: data=%h required %h",
                                     rx, out_data, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                        rx++;
                    end
                end
            end
        end
        out_ready = 1'b0;
        n_checks++;
        if (rx != 20 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_total: rx=%0d cnt=%0d required 20 0", rx, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] st;
        int lat;
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pop: cnt=%0d emp=%b required 0 1", count, empty);
        end
        do_write(16'hC001, 1'b0, st, lat);
        n_checks++;
        if (out_data !== 16'hC001 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL empty_pop_ptr: data=%h cnt=%0d required c001 1", out_data, count);
        end
        do_write(16'hC002, 1'b0, st, lat);
        write_req = 1'b1;
        wdata     = 16'hC003;
        last_item = 1'b1;
        step();
        write_req = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (stall !== 2'b11 || count !== 5'd2 || out_data !== 16'hC002) begin
            n_fail++;
            $display("FAIL push_pop: st=%b cnt=%0d data=%h required 11 2 c002",
                     stall, count, out_data);
        end
        step();
    endtask

    task automatic test_error();
        do_reset();
        out_ready = 1'b0;
        write_req = 1'b1;
        wdata     = 16'h1111;
        last_item = 1'b0;
        step();
        wdata     = 16'h2222;
        last_item = 1'b1;
        step();
        write_req = 1'b0;
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: err=%b required 1", error);
        end
        step();
        n_checks++;
        if (stall !== 2'b10 || count !== 5'd1 || out_data !== 16'h1111) begin
            n_fail++;
            $display("FAIL err_ack: st=%b cnt=%0d data=%h required 10 1 1111",
                     stall, count, out_data);
        end
        for (int k = 0; k < 5; k++) step();
        n_checks++;
        if (error !== 1'b1 || count !== 5'd1 || stall !== 2'b00) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b cnt=%0d st=%b required 1 1 00",
                     error, count, stall);
        end
    endtask

    task automatic test_clear();
        logic [1:0] st;
        int lat;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) do_write(16'h3000 + 16'(i), 1'b0, st, lat);
        write_req = 1'b1;
        wdata     = 16'hDEAD;
        step();
        step();
        write_req = 1'b0;
        n_checks++;
        if (error !== 1'b1 || stall !== 2'b00 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_pre: err=%b st=%b full=%b required 1 00 1", error, stall, full);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || error !== 1'b0 ||
            stall !== 2'b00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_state: cnt=%0d emp=%b err=%b st=%b ov=%b required 0 1 0 00 0",
                     count, empty, error, stall, out_valid);
        end
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (count !== 5'd0 || stall !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_discard: cnt=%0d st=%b required 0 00", count, stall);
        end
        do_write(16'h7777, 1'b1, st, lat);
        n_checks++;
        if (st !== 2'b11 || lat != 3 || count !== 5'd1 || out_data !== 16'h7777) begin
            n_fail++;
            $display("FAIL clr_idle: st=%b lat=%0d cnt=%0d data=%h required 11 3 1 7777",
                     st, lat, count, out_data);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        out_ready = 1'b0;
        write_req = 1'b1;
        wdata     = 16'h9999;
        last_item = 1'b0;
        step();
        write_req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (count !== 5'd0 || stall !== 2'b00 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: cnt=%0d st=%b emp=%b required 0 00 1", count, stall, empty);
        end
        #2;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (count !== 5'd0 || stall !== 2'b00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_discard: cnt=%0d st=%b ov=%b required 0 00 0",
                     count, stall, out_valid);
        end
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        write_req = 1'b0;
        wdata     = '0;
        last_item = 1'b0;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || stall !== 2'b00 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL power_on: cnt=%0d emp=%b st=%b err=%b required 0 1 00 0",
                     count, empty, stall, error);
        end
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_error();
        test_clear();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
